// File: rtl/multiplicador_acumulador_if.sv
// Start/Done handshake and operand/result bus of the sequential multiply-accumulate unit.
// Shared by the controller (master) and the datapath (slave).
`timescale 1ns/1ps
interface multiplicador_acumulador_if #(
   parameter int tamanyo = 32
) ();
   logic                     Start;
   logic [tamanyo-1:0]       Mul_A;
   logic [tamanyo-1:0]       Mul_B;
   logic [tamanyo-1:0]       Add;
   logic [2*tamanyo-1:0]     Prod;
   logic                     Done;
   logic                     Busy;

   modport master (
      output Start, Mul_A, Mul_B, Add,
      input  Prod, Done, Busy
   );

   modport slave (
      input  Start, Mul_A, Mul_B, Add,
      output Prod, Done, Busy
   );
endinterface

// File: rtl/multiplicador_acumulador.sv
// Radix-2 shift-add multiply-accumulate: Prod = Mul_A * Mul_B + Add, one multiplier bit per clock.
// Fixed N-cycle latency; level Start, one-cycle Done, same handshake as the sequential divider.
`timescale 1ns/1ps
module multiplicador_acumulador #(
   parameter int tamanyo = 32
) (
   input  logic                        CLK,
   input  logic                        RSTa,
   multiplicador_acumulador_if.slave   bus
);
   localparam int CW = (tamanyo > 1) ? $clog2(tamanyo) : 1;
   localparam logic [CW-1:0] CONT_INIT = CW'(tamanyo - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                     state_q;
   logic unsigned [2*tamanyo-1:0] p_q;
   logic unsigned [2*tamanyo-1:0] as_q;
   logic unsigned [tamanyo-1:0]   bs_q;
   logic [CW-1:0]              cont_q;
   logic                       done_q;
   logic unsigned [2*tamanyo-1:0] p_d;

   // The sum cannot exceed 2^2N - 2^N, so the carry-out is dropped by design.
   always_comb begin
      p_d = p_q;
      if (bs_q[0]) p_d = p_q + as_q;
   end

   always_ff @(posedge CLK or negedge RSTa) begin
      if (!RSTa) begin
         state_q <= S_IDLE;
         p_q     <= '0;
         as_q    <= '0;
         bs_q    <= '0;
         cont_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.Start) begin
                  p_q     <= {{tamanyo{1'b0}}, bus.Add};
                  as_q    <= {{tamanyo{1'b0}}, bus.Mul_A};
                  bs_q    <= bus.Mul_B;
                  cont_q  <= CONT_INIT;
                  state_q <= S_CALC;
               end
            end
            S_CALC: begin
               p_q    <= p_d;
               as_q   <= as_q << 1;
               bs_q   <= bs_q >> 1;
               cont_q <= cont_q - 1'b1;
               if (cont_q == '0) begin
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               // Wait for a Start low phase so a held Start cannot re-trigger.
               if (!bus.Start) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.Prod = p_q;
   assign bus.Done = done_q;
   assign bus.Busy = (state_q == S_CALC) || (state_q == S_DONE);
endmodule

// File: tb/tb_multiplicador_acumulador.sv
// Bench for multiplicador_acumulador: directed and random MAC operations at N=8, divider round-trip at N=32.
`timescale 1ns/1ps
module tb_multiplicador_acumulador;
   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   multiplicador_acumulador_if #(.tamanyo(8))  if8 ();
   multiplicador_acumulador_if #(.tamanyo(32)) if32 ();

   multiplicador_acumulador #(.tamanyo(8)) dut8 (
      .CLK  (clk),
      .RSTa (rst_n),
      .bus  (if8)
   );

   multiplicador_acumulador #(.tamanyo(32)) dut32 (
      .CLK  (clk),
      .RSTa (rst_n),
      .bus  (if32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One 8-bit operation; reference value is plain arithmetic on the sampled operands.
   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ad,
                       input bit hold, input bit scramble);
      logic [63:0] exp;
      int          lat;
      exp = 64'(a) * 64'(b) + 64'(ad);
      if8.Mul_A = a;
      if8.Mul_B = b;
      if8.Add   = ad;
      if8.Start = 1'b1;
      tick();
      chk("busy_at_accept", 64'(if8.Busy), 64'd1);
      chk("done_at_accept", 64'(if8.Done), 64'd0);
      if (!hold) if8.Start = 1'b0;
      lat = 0;
      while (if8.Done !== 1'b1 && lat < 40) begin
         if (scramble) begin
            if8.Mul_A = 8'($urandom);
            if8.Mul_B = 8'($urandom);
            if8.Add   = 8'($urandom);
         end
         tick();
         lat++;
      end
      chk("latency8", 64'(lat), 64'd8);
      chk("prod8", if8.Prod, exp);
      chk("busy_at_done", 64'(if8.Busy), 64'd1);
      if (hold) begin
         repeat (5) begin
            tick();
            chk("hold_done", 64'(if8.Done), 64'd0);
            chk("hold_busy", 64'(if8.Busy), 64'd1);
            chk("hold_prod", if8.Prod, exp);
         end
         if8.Start = 1'b0;
      end
      tick();
      chk("done_pulse_end", 64'(if8.Done), 64'd0);
      chk("prod_stable", if8.Prod, exp);
      chk("busy_after", 64'(if8.Busy), 64'd0);
   endtask

   // Rebuild Num from the quotient and remainder of Num / Den.
   task automatic run32(input logic [31:0] num, input logic [31:0] den);
      logic [31:0] coc;
      logic [31:0] res;
      int          lat;
      coc = num / den;
      res = num % den;
      if32.Mul_A = den;
      if32.Mul_B = coc;
      if32.Add   = res;
      if32.Start = 1'b1;
      tick();
      if32.Start = 1'b0;
      lat = 0;
      while (if32.Done !== 1'b1 && lat < 80) begin
         tick();
         lat++;
      end
      chk("latency32", 64'(lat), 64'd32);
      chk("roundtrip_lo", 64'(if32.Prod[31:0]), 64'(num));
      chk("roundtrip_hi", 64'(if32.Prod[63:32]), 64'd0);
      tick();
   endtask

   initial begin
      logic [7:0]  pre_prod;
      logic [31:0] num;
      logic [31:0] den;
      tests = 0;
      fails = 0;
      rst_n = 1'b1;
      if8.Start = 1'b0;  if8.Mul_A = '0;  if8.Mul_B = '0;  if8.Add = '0;
      if32.Start = 1'b0; if32.Mul_A = '0; if32.Mul_B = '0; if32.Add = '0;
      #2 rst_n = 1'b0;
      repeat (3) tick();
      chk("rst_prod", if8.Prod, 64'd0);
      chk("rst_done", 64'(if8.Done), 64'd0);
      chk("rst_busy", 64'(if8.Busy), 64'd0);
      chk("rst_prod32", if32.Prod, 64'd0);
      rst_n = 1'b1;
      repeat (20) begin
         tick();
         chk("idle_prod", if8.Prod, 64'd0);
         chk("idle_done", 64'(if8.Done), 64'd0);
         chk("idle_busy", 64'(if8.Busy), 64'd0);
      end

      run8(8'd6, 8'd7, 8'd5, 1'b0, 1'b0);
      run8(8'd255, 8'd255, 8'd255, 1'b0, 1'b0);
      run8(8'd123, 8'd0, 8'd9, 1'b0, 1'b0);
      run8(8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
      run8(8'd200, 8'd171, 8'd33, 1'b1, 1'b0);
      run8(8'd91, 8'd202, 8'd17, 1'b0, 1'b1);

      // Prod holds in S_IDLE regardless of operand inputs.
      if8.Mul_A = 8'd1; if8.Mul_B = 8'd1; if8.Add = 8'd1;
      repeat (3) tick();
      chk("idle_hold_prod", if8.Prod, 64'(91 * 202 + 17));

      repeat (20) run8(8'($urandom), 8'($urandom), 8'($urandom),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      // Reset at the 4th S_CALC cycle.
      if8.Mul_A = 8'd13; if8.Mul_B = 8'd11; if8.Add = 8'd77;
      if8.Start = 1'b1;
      tick();
      if8.Start = 1'b0;
      repeat (3) tick();
      pre_prod = if8.Prod[7:0];
      chk("midop_busy", 64'(if8.Busy), 64'd1);
      chk("midop_partial_nonzero", 64'(pre_prod != 8'd0), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_prod", if8.Prod, 64'd0);
      chk("midrst_done", 64'(if8.Done), 64'd0);
      chk("midrst_busy", 64'(if8.Busy), 64'd0);
      tick();
      rst_n = 1'b1;
      repeat (12) begin
         tick();
         chk("postrst_done", 64'(if8.Done), 64'd0);
         chk("postrst_busy", 64'(if8.Busy), 64'd0);
         chk("postrst_prod", if8.Prod, 64'd0);
      end
      run8(8'd13, 8'd11, 8'd77, 1'b0, 1'b0);

      for (int i = 0; i < 1000; i++) begin
         num = $urandom;
         if (i % 2 == 0) den = 32'($urandom_range(1, 255));
         else            den = $urandom;
         if (den == 32'd0) den = 32'd1;
         run32(num, den);
      end
      run32(32'hFFFF_FFFF, 32'd1);
      run32(32'd0, 32'hFFFF_FFFF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/multiplicador_acumulador.md
# multiplicador_acumulador

Sequential radix-2 shift-add multiply-accumulate unit computing Prod = Mul_A × Mul_B + Add on unsigned operands, one multiplier bit per clock. It is the inverse datapath of the sequential divider. Fed Den, Coc and Res, it rebuilds Num, so it serves both as a reconstruction and self-check stage behind the divider and as a general multiplier in the processing chain. It uses the same level-based Start / one-cycle Done handshake as the divider, so both blocks can be driven by the same controller.

## Interface
- tamanyo, 32, operand width N in bits (N ≥ 2); product width is 2N
- CLK  in  1  system clock, rising edge
- RSTa  in  1  asynchronous, active-low reset
- Start  in  1  level request; accepted only in S_IDLE
- Mul_A  in  tamanyo  multiplicand, unsigned (divider Den)
- Mul_B  in  tamanyo  multiplier, unsigned (divider Coc)
- Add  in  tamanyo  addend, unsigned (divider Res)
- Prod  out  2·tamanyo  result register, unsigned
- Done  out  1  one-cycle completion pulse
- Busy  out  1  high in S_CALC and S_DONE

## Operation
- Internal registers:
  - P: 2N-bit accumulator, drives Prod.
  - AS: 2N-bit shifted multiplicand.
  - BS: N-bit shifted multiplier.
  - CONT: $clog2(N)-bit down-counter.
  - state: S_IDLE, S_CALC, S_DONE.
- Arithmetic: unsigned, no overflow possible. The maximum value (2^N−1)² + (2^N−1) = 2^2N − 2^N fits in 2N bits. The adder is 2N bits wide with no carry-out.
- S_IDLE:
  - Done=0. P holds the previous result.
  - If Start=1: P←{N'0, Add}, AS←{N'0, Mul_A}, BS←Mul_B, CONT←N−1, go to S_CALC.
  - Operands are sampled only on this edge. Later input changes are ignored.
- S_CALC, every cycle:
  - If BS[0]=1: P←P+AS.
  - AS←AS<<1, BS←BS>>1, CONT←CONT−1.
  - If CONT==0: Done←1 and go to S_DONE. Otherwise stay.
  - Start is ignored in this state.
- S_DONE:
  - Done←0, so Done is high for exactly one cycle.
  - Prod is valid and stable from the first S_DONE cycle until the next acceptance.
  - If Start=0: go to S_IDLE. While Start stays 1, remain in S_DONE. No re-trigger without a Start low phase.
- Reset (RSTa=0, any time, including mid-calculation):
  - Immediately state=S_IDLE.
  - P, AS, BS, CONT cleared, so Prod=0, Done=0, Busy=0.
  - Any partial result is discarded.
- Unused state encodings return to S_IDLE on the next clock.

## Timing
- Edge k: Start=1 sampled in S_IDLE. From edge k the block is in S_CALC and Busy=1.
- Edges k+1 … k+N: the N accumulate steps.
- After edge k+N: S_DONE, Done=1 and Prod final. Fixed latency of N clocks from acceptance to Done, independent of operand values (no early exit on BS==0).
- Edge k+N+1: Done=0.
  - If Start was already 0 at that edge: S_IDLE, Busy=0, earliest next acceptance at edge k+N+2.
  - If Start is still 1: remain in S_DONE until Start is sampled low.
- Minimum issue interval: N+2 cycles.
- Prod changes only on an acceptance edge or during S_CALC. It is never updated in S_IDLE or S_DONE.

## Test plan
- Reset values, tamanyo=8: assert RSTa=0 → Prod=0, Done=0, Busy=0. Release RSTa with Start=0 → outputs unchanged for 20 cycles.
- Basic MAC, tamanyo=8: Mul_A=6, Mul_B=7, Add=5, one Start pulse → Done high for exactly one cycle, 8 clocks after acceptance, Prod=47, Busy low afterwards.
- Extremes, tamanyo=8:
  - Mul_A=Mul_B=Add=255 → Prod=65280 (0xFF00).
  - Mul_B=0, Add=9 → Prod=9 with the same 8-cycle latency.
  - Mul_A=0, Mul_B=0, Add=0 → Prod=0.
- Divider round-trip, tamanyo=32: for 1000 random (Num, Den≠0), feed Den/Coc/Res from the divider → Prod[31:0]=Num, Prod[63:32]=0.
- Handshake:
  - Hold Start=1 through completion → single Done pulse, Busy stays 1, no second operation until Start low then high.
  - Change the operand inputs during S_CALC → result unaffected.
- Reset mid-operation: assert RSTa at the 4th S_CALC cycle → Prod=0, Done never pulses. A new Start after release gives the correct result with full latency.
